conv2d_dilated_pad_window_gen: RTL and testbench
================================================

# conv2d_dilated_pad_window_gen

Upstream feeder for the dilated, padded standard 2D convolution stage. It captures one square single-channel input frame in raster order. It then streams, for every output position, the KH×KW dilated kernel taps in serial order. Taps that fall in the padding region are emitted as zero. The convolution MAC pairs each beat with the weight at `tap_idx` and sees `first_tap`/`last_tap` per output position.

## Interface
Parameters:
- DATA_W, 32, pixel word width
- IMG, 8, input height = width
- KH, 3, kernel height
- KW, 5, kernel width
- STRIDE, 1, stride (both axes)
- PH, 2, padding top/bottom
- PW, 4, padding left/right
- DH, 2, dilation height
- DW, 3, dilation width
- Derived: OH = (IMG+2·PH−DH·(KH−1)−1)/STRIDE+1 = 8; OW = (IMG+2·PW−DW·(KW−1)−1)/STRIDE+1 = 4

Ports:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- valid_in, in, 1, input pixel valid
- ready_out, out, 1, block accepts a pixel (high only in LOAD)
- input_data, in, DATA_W, pixel, raster order (row-major)
- valid_out, out, 1, tap beat valid
- ready_in, in, 1, downstream accepts beat
- output_data, out, DATA_W, tap pixel, or 0 if padded
- tap_idx, out, $clog2(KH·KW), kh·KW+kw (weight address)
- first_tap, out, 1, beat is tap 0 of an output position
- last_tap, out, 1, beat is tap KH·KW−1
- frame_done, out, 1, one-cycle pulse after the final beat is accepted

## Operation
- FSM states: LOAD, STREAM.
- LOAD:
  - ready_out=1 and valid_out=0.
  - Each valid_in&&ready_out writes input_data to store[wr_ptr] and increments wr_ptr.
  - On the beat where wr_ptr=IMG²−1, go to STREAM with all counters cleared.
- STREAM:
  - ready_out=0. Input is back-pressured and never dropped.
  - Counters, nested outer→inner: oh, ow, kh, kw.
  - Signed coordinates: ih = oh·STRIDE − PH + kh·DH; iw = ow·STRIDE − PW + kw·DW. Compute in signed width $clog2(IMG+2·max(PH,PW)+DH·KH+DW·KW)+2.
  - output_data = store[ih·IMG+iw] when 0≤ih<IMG and 0≤iw<IMG, else 0.
  - A handshake (valid_out&&ready_in) advances kw. kw wraps to 0 at KW−1 and carries into kh, kh into ow, ow into oh.
  - On the handshake with oh=OH−1, ow=OW−1, kh=KH−1, kw=KW−1:
    - frame_done pulses on the next cycle.
    - FSM returns to LOAD.
    - wr_ptr and all counters are zero.
- Total beats per frame: OH·OW·KH·KW = 480.
- Multi-channel and multi-batch operation is done by repeating frames. This block keeps no state between frames.

## Timing
- Reset values:
  - state=LOAD; ready_out=1.
  - valid_out=0, output_data=0, tap_idx=0, first_tap=0, last_tap=0, frame_done=0.
  - All counters 0. Store contents undefined.
- Latency:
  - The first STREAM beat is valid in the cycle after the last pixel handshake.
  - Each beat holds until accepted.
  - Full throughput is 1 beat/cycle when ready_in=1.
- AXI-style rule: while valid_out=1 and ready_in=0, output_data, tap_idx, first_tap and last_tap hold stable.
- valid_out and all data outputs come from registered state/counters and the store. There is no combinational path from ready_in or valid_in to any output.
- Reset mid-frame (either state) aborts: LOAD, counters zero, no frame_done.
- No overlap: the next frame's pixels are not accepted until the cycle after the final beat.

## Structure
- Package conv2d_pkg holds:
  - DATA_W
  - the state enum (LOAD, STREAM)
  - a constant function for OH/OW
  - a constant function for signed coordinate width
- Sub-module conv2d_frame_store:
  - IMG²×DATA_W register array
  - one synchronous write port
  - one asynchronous read port
- Sequencer, counters, bounds check and zero mux live in the top.

## Test plan
- Reset: assert rst_n=0 → all outputs at reset values, ready_out=1. Release → no valid_out until a full frame is loaded.
- Load pixel value r·8+c+1, ready_in=1 constantly:
  - beat 0 = 0 (ih=−2, iw=−4), first_tap=1, tap_idx=0.
  - beat 7 = 3 (ih=0, iw=2), tap_idx=7.
  - 480 beats total, frame_done pulse once.
- Last output position (oh=7, ow=3):
  - tap_idx 7 = 62.
  - tap_idx 14 = 0, with last_tap=1.
- Random ready_in stalls (~50%) → beat sequence identical to the no-stall run; outputs stable while stalled.
- Drive valid_in continuously during STREAM → ready_out=0, no store corruption. The second frame loads only after frame_done, and its results match its own data.
- Assert rst_n mid-STREAM at beat 200 → valid_out=0 immediately and no frame_done. A fresh frame then streams correctly from beat 0.

Source files
------------

// File: rtl/conv2d_dilated_pad_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_pkg
// Description : Shared word width, sequencer state encoding and constant
//               helpers for the dilated/padded conv2d window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package conv2d_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Output extent along one axis for a padded, dilated, strided kernel.
  function automatic int out_dim(input int img, input int pad, input int dil,
                                 input int k, input int stride);
    return (img + 2 * pad - dil * (k - 1) - 1) / stride + 1;
  endfunction

  // Signed width wide enough for every tap coordinate, including negative
  // coordinates inside the top/left padding.
  function automatic int coord_w(input int img, input int ph, input int pw,
                                 input int dh, input int kh, input int dw,
                                 input int kw);
    int pmax;
    pmax = (ph > pw) ? ph : pw;
    return $clog2(img + 2 * pmax + dh * kh + dw * kw) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv2d_dilated_pad_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_dilated_pad_window_gen_if
// Description : Pixel-in / tap-out handshake bundle of the window generator.
//               slave = generator view, master = surrounding pipeline view.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv2d_dilated_pad_window_gen_if #(
  parameter int DATA_W = 32,
  parameter int TAP_W  = 4
);
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] input_data;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] output_data;
  logic [TAP_W-1:0]  tap_idx;
  logic              first_tap;
  logic              last_tap;
  logic              frame_done;

  modport slave (
    input  valid_in, input_data, ready_in,
    output ready_out, valid_out, output_data, tap_idx, first_tap, last_tap,
           frame_done
  );

  modport master (
    output valid_in, input_data, ready_in,
    input  ready_out, valid_out, output_data, tap_idx, first_tap, last_tap,
           frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv2d_dilated_pad_window_gen_frame_store.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_frame_store
// Description : One-frame pixel store: synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_frame_store #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents carry no reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/conv2d_dilated_pad_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_dilated_pad_window_gen
// Description : Captures one IMGxIMG frame, then streams the KHxKW dilated
//               taps of every output position; padded taps read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_dilated_pad_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG    = 8,
  parameter int KH     = 3,
  parameter int KW     = 5,
  parameter int STRIDE = 1,
  parameter int PH     = 2,
  parameter int PW     = 4,
  parameter int DH     = 2,
  parameter int DW     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  conv2d_dilated_pad_window_gen_if.slave bus
);
  import conv2d_pkg::*;

  localparam int OH    = out_dim(IMG, PH, DH, KH, STRIDE);
  localparam int OW    = out_dim(IMG, PW, DW, KW, STRIDE);
  localparam int CW    = coord_w(IMG, PH, PW, DH, KH, DW, KW);
  localparam int NPIX  = IMG * IMG;
  localparam int AW    = $clog2(NPIX);
  localparam int TAP_W = $clog2(KH * KW);
  localparam int OH_W  = (OH > 1) ? $clog2(OH) : 1;
  localparam int OW_W  = (OW > 1) ? $clog2(OW) : 1;
  localparam int KH_W  = (KH > 1) ? $clog2(KH) : 1;
  localparam int KW_W  = (KW > 1) ? $clog2(KW) : 1;

  localparam logic [0:0] C_ST_LOAD   = LOAD;
  localparam logic [0:0] C_ST_STREAM = STREAM;

  logic [0:0]        r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [OH_W-1:0]   r_oh;
  logic [OW_W-1:0]   r_ow;
  logic [KH_W-1:0]   r_kh;
  logic [KW_W-1:0]   r_kw;
  logic              r_frame_done;

  logic              w_loading;
  logic              w_streaming;
  logic              w_pix_acc;
  logic              w_beat_acc;
  logic              w_kw_last;
  logic              w_kh_last;
  logic              w_ow_last;
  logic              w_oh_last;
  logic signed [CW-1:0] w_ih;
  logic signed [CW-1:0] w_iw;
  logic              w_in_bounds;
  logic [AW-1:0]     w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_loading   = (r_state == C_ST_LOAD);
  assign w_streaming = (r_state == C_ST_STREAM);
  assign w_pix_acc   = bus.valid_in && w_loading;
  assign w_beat_acc  = w_streaming && bus.ready_in;

  assign w_kw_last = (r_kw == KW_W'(KW - 1));
  assign w_kh_last = (r_kh == KH_W'(KH - 1));
  assign w_ow_last = (r_ow == OW_W'(OW - 1));
  assign w_oh_last = (r_oh == OH_W'(OH - 1));

  // Tap coordinate in input space; negative or >= IMG means padding.
  assign w_ih = CW'(int'(r_oh) * STRIDE - PH + int'(r_kh) * DH);
  assign w_iw = CW'(int'(r_ow) * STRIDE - PW + int'(r_kw) * DW);
  assign w_in_bounds = (int'(w_ih) >= 0) && (int'(w_ih) < IMG) &&
                       (int'(w_iw) >= 0) && (int'(w_iw) < IMG);
  // Address is junk for padded taps, but the zero mux hides it.
  assign w_rd_addr = AW'(int'(w_ih) * IMG + int'(w_iw));

  conv2d_frame_store #(
    .DATA_W (DATA_W),
    .DEPTH  (NPIX),
    .ADDR_W (AW)
  ) u_store (
    .clk     (clk),
    .wr_en   (w_pix_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.input_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // All outputs derive from state/counters/store only, never from ready_in.
  assign bus.ready_out   = w_loading;
  assign bus.valid_out   = w_streaming;
  assign bus.output_data = (w_streaming && w_in_bounds) ? w_rd_data : '0;
  assign bus.tap_idx     = w_streaming ? TAP_W'(int'(r_kh) * KW + int'(r_kw)) : '0;
  assign bus.first_tap   = w_streaming && (r_kh == '0) && (r_kw == '0);
  assign bus.last_tap    = w_streaming && w_kh_last && w_kw_last;
  assign bus.frame_done  = r_frame_done;

  // Load/stream sequencer with nested oh > ow > kh > kw tap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_ST_LOAD;
      r_wr_ptr     <= '0;
      r_oh         <= '0;
      r_ow         <= '0;
      r_kh         <= '0;
      r_kw         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_loading) begin
        if (w_pix_acc) begin
          if (r_wr_ptr == AW'(NPIX - 1)) begin
            r_wr_ptr <= '0;
            r_state  <= C_ST_STREAM;
            r_oh     <= '0;
            r_ow     <= '0;
            r_kh     <= '0;
            r_kw     <= '0;
          end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
        end
      end else if (w_beat_acc) begin
        if (w_kw_last) begin
          r_kw <= '0;
          if (w_kh_last) begin
            r_kh <= '0;
            if (w_ow_last) begin
              r_ow <= '0;
              if (w_oh_last) begin
                r_oh         <= '0;
                r_state      <= C_ST_LOAD;
                r_frame_done <= 1'b1;
              end else begin
                r_oh <= r_oh + OH_W'(1);
              end
            end else begin
              r_ow <= r_ow + OW_W'(1);
            end
          end else begin
            r_kh <= r_kh + KH_W'(1);
          end
        end else begin
          r_kw <= r_kw + KW_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_dilated_pad_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_dilated_pad_window_gen
// Description : Directed, table-driven bench for the conv2d window generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_dilated_pad_window_gen;

  localparam int NBEAT = 480;
  localparam int NPIX  = 64;

  typedef struct {
    int          beat;
    logic [31:0] data;
    int          tap;
    bit          first;
    bit          last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  conv2d_dilated_pad_window_gen_if #(.DATA_W(32), .TAP_W(4)) bus ();

  conv2d_dilated_pad_window_gen #(
    .DATA_W (32), .IMG (8), .KH (3), .KW (5), .STRIDE (1),
    .PH (2), .PW (4), .DH (2), .DW (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem   [NPIX];
  logic [31:0] frm_a [NPIX];
  logic [31:0] frm_b [NPIX];
  logic [31:0] frm_c [NPIX];
  logic [31:0] cap_data  [NBEAT];
  logic [3:0]  cap_tap   [NBEAT];
  bit          cap_first [NBEAT];
  bit          cap_last  [NBEAT];
  vec_t        tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel for beat n of the current frame held in mem.
  function automatic logic [31:0] model_data(input int n);
    int kw, kh, ow, oh, ih, iw;
    kw = n % 5;
    kh = (n / 5) % 3;
    ow = (n / 15) % 4;
    oh = n / 60;
    ih = oh - 2 + 2 * kh;
    iw = ow - 4 + 3 * kw;
    if (ih >= 0 && ih < 8 && iw >= 0 && iw < 8) return mem[ih * 8 + iw];
    return 32'd0;
  endfunction

  task automatic load_frame(input int which);
    int i, cyc, vo_err, fd_seen;
    bit ra;
    for (int k = 0; k < NPIX; k++)
      mem[k] = (which == 0) ? frm_a[k] : (which == 1) ? frm_b[k] : frm_c[k];
    i = 0; cyc = 0; vo_err = 0; fd_seen = 0;
    while (i < NPIX && cyc < 1000) begin
      bus.valid_in   = 1'b1;
      bus.input_data = mem[i];
      ra = bus.ready_out;
      if (bus.valid_out !== 1'b0) vo_err++;
      step();
      cyc++;
      if (bus.frame_done !== 1'b0) fd_seen++;
      if (ra) i++;
    end
    bus.valid_in = 1'b0;
    check("load_pixels_accepted", i, NPIX);
    check("load_no_valid_out", vo_err, 0);
    check("load_no_frame_done", fd_seen, 0);
    check("first_beat_latency", bus.valid_out, 1);
  endtask

  task automatic stream_frame(input int stall_pct, input bit vin, input logic [31:0] vin_data,
                              input int limit);
    int n, cyc, stab_err, ro_err, fd_err, vo_err;
    bit rdy, held;
    logic [31:0] sd;
    logic [3:0]  st;
    bit sf, sl;
    n = 0; cyc = 0; stab_err = 0; ro_err = 0; fd_err = 0; vo_err = 0; held = 0;
    sd = '0; st = '0; sf = 0; sl = 0;
    while (n < limit && cyc < 5000) begin
      rdy = ($urandom_range(99) >= stall_pct);
      bus.ready_in   = rdy;
      bus.valid_in   = vin;
      bus.input_data = vin_data;
      if (held && (bus.valid_out !== 1'b1 || bus.output_data !== sd || bus.tap_idx !== st ||
                   bus.first_tap !== sf || bus.last_tap !== sl)) stab_err++;
      if (bus.ready_out !== 1'b0)  ro_err++;
      if (bus.frame_done !== 1'b0) fd_err++;
      if (bus.valid_out !== 1'b1)  vo_err++;
      held = 0;
      if (bus.valid_out === 1'b1) begin
        if (rdy) begin
          cap_data[n]  = bus.output_data;
          cap_tap[n]   = bus.tap_idx;
          cap_first[n] = bus.first_tap;
          cap_last[n]  = bus.last_tap;
          n++;
        end else begin
          held = 1;
          sd = bus.output_data; st = bus.tap_idx;
          sf = bus.first_tap;   sl = bus.last_tap;
        end
      end
      step();
      cyc++;
    end
    check("stream_beat_count", n, limit);
    check("stream_ready_out_low", ro_err, 0);
    check("stream_valid_out_high", vo_err, 0);
    check("stream_no_early_frame_done", fd_err, 0);
    if (stall_pct > 0) check("stall_outputs_hold", stab_err, 0);
    if (limit == NBEAT) begin
      check("frame_done_pulse", bus.frame_done, 1);
      check("back_to_load", bus.ready_out, 1);
      check("valid_out_drops", bus.valid_out, 0);
    end
  endtask

  task automatic compare_beats(input string tag, input int cnt);
    logic [31:0] ed;
    for (int n = 0; n < cnt; n++) begin
      ed = model_data(n);
      n_cmp++;
      if (cap_data[n] !== ed || cap_tap[n] !== 4'(n % 15) ||
          cap_first[n] !== (n % 15 == 0) || cap_last[n] !== (n % 15 == 14)) begin
        n_bad++;
        $display("FAIL %s beat %0d: got data=%0h tap=%0d first=%0b last=%0b, expected data=%0h tap=%0d first=%0b last=%0b",
                 tag, n, cap_data[n], cap_tap[n], cap_first[n], cap_last[n],
                 ed, n % 15, (n % 15 == 0), (n % 15 == 14));
      end
    end
  endtask

  initial begin
    int vo_seen, fd_seen;

    for (int k = 0; k < NPIX; k++) begin
      frm_a[k] = 32'(k + 1);
      frm_b[k] = $urandom;
      frm_c[k] = $urandom;
    end
    tbl[0] = '{0,   32'd0,  0,  1'b1, 1'b0};
    tbl[1] = '{7,   32'd3,  7,  1'b0, 1'b0};
    tbl[2] = '{14,  32'd0,  14, 1'b0, 1'b1};
    tbl[3] = '{15,  32'd0,  0,  1'b1, 1'b0};
    tbl[4] = '{72,  32'd27, 12, 1'b0, 1'b0};
    tbl[5] = '{278, 32'd40, 8,  1'b0, 1'b0};
    tbl[6] = '{472, 32'd62, 7,  1'b0, 1'b0};
    tbl[7] = '{479, 32'd0,  14, 1'b0, 1'b1};

    // Reset state
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.input_data = '0; bus.ready_in = 1'b0;
    step(); step();
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_ready_out", bus.ready_out, 1);
    check("rst_output_data", bus.output_data, 0);
    check("rst_tap_idx", bus.tap_idx, 0);
    check("rst_first_tap", bus.first_tap, 0);
    check("rst_last_tap", bus.last_tap, 0);
    check("rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    bus.ready_in = 1'b1;
    vo_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.valid_out !== 1'b0) vo_seen++;
    end
    check("idle_no_valid_out", vo_seen, 0);

    // Frame 1: ramp pattern, no stalls, plus hand-computed vectors
    load_frame(0);
    stream_frame(0, 1'b0, 32'd0, NBEAT);
    compare_beats("ramp_nostall", NBEAT);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("vec_b%0d_data", tbl[i].beat), cap_data[tbl[i].beat], tbl[i].data);
      check($sformatf("vec_b%0d_tap", tbl[i].beat), cap_tap[tbl[i].beat], tbl[i].tap);
      check($sformatf("vec_b%0d_first", tbl[i].beat), cap_first[tbl[i].beat], tbl[i].first);
      check($sformatf("vec_b%0d_last", tbl[i].beat), cap_last[tbl[i].beat], tbl[i].last);
    end

    // Frame 2: same ramp, random stalls, next frame's pixel pushed during stream
    load_frame(0);
    stream_frame(50, 1'b1, frm_b[0], NBEAT);
    compare_beats("ramp_stall", NBEAT);

    // Frame 3: loads right after frame_done, aborted by reset at beat 200
    load_frame(1);
    stream_frame(0, 1'b0, 32'd0, 200);
    compare_beats("rand_partial", 200);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", bus.valid_out, 0);
    check("midrst_ready_out", bus.ready_out, 1);
    check("midrst_frame_done", bus.frame_done, 0);
    check("midrst_tap_idx", bus.tap_idx, 0);
    check("midrst_output_data", bus.output_data, 0);
    step();
    rst_n = 1'b1;
    vo_seen = 0; fd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.valid_out !== 1'b0) vo_seen++;
      if (bus.frame_done !== 1'b0) fd_seen++;
    end
    check("postrst_no_valid_out", vo_seen, 0);
    check("postrst_no_frame_done", fd_seen, 0);

    // Frame 4: fresh frame after abort, moderate stalls
    load_frame(2);
    stream_frame(30, 1'b0, 32'd0, NBEAT);
    compare_beats("fresh_after_reset", NBEAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
